// File: rtl/updown_ctrl.sv
// Wishbone/LA-controlled sequencer for an external up/down counter: bounded step runs,
// optional auto-reverse, load strobes and a completion interrupt. Holds no count state.
module updown_ctrl #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             la_ovr_i,
  input  logic [1:0]       la_cmd_i,
  input  logic [WIDTH-1:0] la_val_i,
  input  logic [WIDTH-1:0] cnt_val_i,
  output logic             cnt_en_o,
  output logic             cnt_dir_o,
  output logic             cnt_load_o,
  output logic [WIDTH-1:0] cnt_load_val_o,
  output logic             irq_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             dir_q, dir_d;
  logic             autorev_q, autorev_d;
  logic             irqen_q, irqen_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;
  logic             en_q, en_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic [31:0]      steps_q, steps_d;
  logic [31:0]      rem_q, rem_d;

  logic             hit, wr, wr_ctrl, wr_steps, wr_load, wr_status;
  logic             cmd_start, cmd_stop, cmd_load;
  logic [WIDTH-1:0] cmd_load_val;
  logic [31:0]      cnt_ext, rd_data;
  logic             unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    // ack_q masks the decode so a held strobe is acked only once
    hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]) & ~ack_q;
    wr        = hit & wbs_we_i;
    wr_ctrl   = wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
    wr_steps  = wr & (wbs_adr_i[3:2] == 2'd1);
    wr_load   = wr & (wbs_adr_i[3:2] == 2'd2);
    wr_status = wr & (wbs_adr_i[3:2] == 2'd3) & wbs_sel_i[0];

    cmd_start    = la_ovr_i ? (la_cmd_i == 2'b01) : (wr_ctrl & wbs_dat_i[0]);
    cmd_stop     = la_ovr_i ? (la_cmd_i == 2'b10) : (wr_ctrl & wbs_dat_i[2]);
    cmd_load     = la_ovr_i ? (la_cmd_i == 2'b11) : wr_load;
    cmd_load_val = la_ovr_i ? la_val_i : wbs_dat_i[WIDTH-1:0];

    cnt_ext = '0;
    cnt_ext[WIDTH-1:0] = cnt_val_i;
    rd_data = '0;
    case (wbs_adr_i[3:2])
      2'd0:    rd_data = {27'd0, irqen_q, autorev_q, 1'b0, dir_q, 1'b0};
      2'd1:    rd_data = (state_q == S_RUN) ? rem_q : steps_q;
      2'd2:    rd_data = cnt_ext;
      default: rd_data = {29'd0, la_ovr_i, done_q, (state_q == S_RUN)};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = hit;
    dat_d      = (hit & ~wbs_we_i) ? rd_data : 32'd0;
    dir_d      = dir_q;
    autorev_d  = autorev_q;
    irqen_d    = irqen_q;
    done_d     = done_q;
    irq_d      = done_q & irqen_q;
    en_d       = 1'b0;
    load_d     = 1'b0;
    load_val_d = load_val_q;
    steps_d    = steps_q;
    rem_d      = rem_q;

    if (wr_ctrl && !la_ovr_i) begin
      dir_d     = wbs_dat_i[1];
      autorev_d = wbs_dat_i[3];
      irqen_d   = wbs_dat_i[4];
    end
    if (wr_steps && !la_ovr_i) begin
      for (int b = 0; b < 4; b++)
        if (wbs_sel_i[b]) steps_d[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
    end
    // clear precedes the FSM so a same-cycle completion keeps DONE set
    if (wr_status && wbs_dat_i[1]) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (cmd_start) begin
          if (steps_q != 32'd0) begin
            state_d = S_RUN;
            rem_d   = steps_q;
            en_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (cmd_load) begin
          load_d     = 1'b1;
          load_val_d = cmd_load_val;
        end
      end
      default: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (rem_q == 32'd1) begin
          if (autorev_q && steps_q != 32'd0) begin
            dir_d = ~dir_d;
            rem_d = steps_q;
            en_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          rem_d = rem_q - 32'd1;
          en_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      dir_q      <= 1'b0;
      autorev_q  <= 1'b0;
      irqen_q    <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      steps_q    <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      dir_q      <= dir_d;
      autorev_q  <= autorev_d;
      irqen_q    <= irqen_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      en_q       <= en_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      steps_q    <= steps_d;
      rem_q      <= rem_d;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign cnt_en_o       = en_q;
  assign cnt_dir_o      = dir_q;
  assign cnt_load_o     = load_q;
  assign cnt_load_val_o = load_val_q;
  assign irq_o          = irq_q;

endmodule
